// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side handshakes and the memory-side bus of the two-port arbiter.
// The arbiter takes the slave view; whatever sits around it takes the master view.
interface mem_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] din0;
    logic [31:0] din1;
    logic        ack0;
    logic        ack1;
    logic        err0;
    logic        err1;
    logic [31:0] dout0;
    logic [31:0] dout1;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_out;
    logic        busy;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, din0, din1, mem_out,
        output ack0, ack1, err0, err1, dout0, dout1, mem_addr, mem_din, mem_we, mem_re, busy
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, din0, din1, mem_out,
        input  ack0, ack1, err0, err1, dout0, dout1, mem_addr, mem_din, mem_we, mem_re, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port word memory.
// Every transaction takes three cycles: grant (IDLE), memory access (ACCESS), ack (RESP).
module mem_arbiter #(
    parameter int unsigned Size = 256
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e      state_q;
    logic        ptr_q;
    logic        gnt_q;
    logic        we_q;
    logic        err_q;
    logic [31:0] addr_q;
    logic [31:0] din_q;
    logic        ack0_q;
    logic        ack1_q;
    logic        err0_q;
    logic        err1_q;
    logic [31:0] dout0_q;
    logic [31:0] dout1_q;

    logic        sel;
    logic [31:0] sel_addr;
    logic [31:0] rdata;

    always_comb begin
        sel      = (bus.req0 && bus.req1) ? ptr_q : bus.req1;
        sel_addr = sel ? bus.addr1 : bus.addr0;
        // Writes and rejected accesses report zero data.
        rdata    = (we_q || err_q) ? 32'd0 : bus.mem_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= 1'b0;
            gnt_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            dout0_q <= '0;
            dout1_q <= '0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            err0_q <= 1'b0;
            err1_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.req0 || bus.req1) begin
                        gnt_q   <= sel;
                        ptr_q   <= ~sel;
                        we_q    <= sel ? bus.we1 : bus.we0;
                        addr_q  <= sel_addr;
                        din_q   <= sel ? bus.din1 : bus.din0;
                        err_q   <= (sel_addr >= Size);
                        state_q <= StAccess;
                    end
                end
                StAccess: begin
                    state_q <= StResp;
                    if (gnt_q) begin
                        ack1_q  <= 1'b1;
                        err1_q  <= err_q;
                        dout1_q <= rdata;
                    end else begin
                        ack0_q  <= 1'b1;
                        err0_q  <= err_q;
                        dout0_q <= rdata;
                    end
                end
                StResp:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Enables are gated by rst directly so a reset edge during ACCESS never writes.
    always_comb begin
        bus.mem_addr = '0;
        bus.mem_din  = '0;
        bus.mem_we   = 1'b0;
        bus.mem_re   = 1'b0;
        if (state_q == StAccess && !err_q) begin
            bus.mem_addr = addr_q;
            bus.mem_din  = we_q ? din_q : 32'd0;
            bus.mem_we   = we_q && !rst;
            bus.mem_re   = !we_q && !rst;
        end
    end

    assign bus.ack0  = ack0_q;
    assign bus.ack1  = ack1_q;
    assign bus.err0  = err0_q;
    assign bus.err1  = err1_q;
    assign bus.dout0 = dout0_q;
    assign bus.dout1 = dout1_q;
    assign bus.busy  = (state_q != StIdle);
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter: a transaction-level model predicts grants,
// memory accesses and responses; a negedge monitor pops and compares them.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.Size(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory attached to the arbiter.
    logic [31:0] mem [256];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_din;
    assign bus.mem_out = bus.mem_re ? mem[bus.mem_addr[7:0]] : 32'd0;

    typedef struct { logic port; logic err; logic [31:0] dout; } rsp_t;
    typedef struct { logic [31:0] addr; logic we; logic [31:0] din; } acc_t;

    rsp_t        rsp_q[$];
    acc_t        acc_q[$];
    logic [31:0] ref_mem [256];
    int unsigned phase = 0;          // cycles left until the arbiter can grant again
    logic        ptr = 1'b0;
    logic        busy_exp = 1'b0;
    logic [31:0] last0 = '0;
    logic [31:0] last1 = '0;
    logic        pend_wr = 1'b0;
    logic [7:0]  pend_addr = '0;
    logic [31:0] pend_data = '0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          ack_port[$];
    int          ack_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called right after each rising edge, while inputs still hold the values that edge saw.
    task automatic model_step();
        rsp_t        r;
        acc_t        a;
        logic        g;
        logic [31:0] ad;
        cyc++;
        if (rst) begin
            rsp_q.delete();
            acc_q.delete();
            phase    = 0;
            ptr      = 1'b0;
            busy_exp = 1'b0;
            last0    = '0;
            last1    = '0;
            pend_wr  = 1'b0;
            return;
        end
        if (pend_wr) ref_mem[pend_addr] = pend_data;
        pend_wr = 1'b0;
        if (phase == 0) begin
            if (bus.req0 || bus.req1) begin
                g      = (bus.req0 && bus.req1) ? ptr : bus.req1;
                ptr    = !g;
                ad     = g ? bus.addr1 : bus.addr0;
                r.port = g;
                a.addr = ad;
                a.we   = g ? bus.we1 : bus.we0;
                a.din  = a.we ? (g ? bus.din1 : bus.din0) : 32'd0;
                if (ad >= 256) begin
                    r.err  = 1'b1;
                    r.dout = '0;
                end else begin
                    r.err  = 1'b0;
                    r.dout = a.we ? 32'd0 : ref_mem[ad[7:0]];
                    acc_q.push_back(a);
                    if (a.we) begin
                        pend_wr   = 1'b1;
                        pend_addr = ad[7:0];
                        pend_data = a.din;
                    end
                end
                rsp_q.push_back(r);
                phase = 2;
            end
        end else begin
            if (phase == 2) check("access_issued", 32'(acc_q.size()), 32'd0);
            else            check("ack_issued", 32'(rsp_q.size()), 32'd0);
            phase--;
        end
        busy_exp = (phase != 0);
    endtask

    // Monitor
    initial begin
        rsp_t r;
        acc_t a;
        forever begin
            @(negedge clk);
            check("busy", 32'(bus.busy), 32'(busy_exp));
            if (!bus.ack0) check("dout0_hold", bus.dout0, last0);
            if (!bus.ack1) check("dout1_hold", bus.dout1, last1);
            if (bus.ack0 || bus.ack1) begin
                check("ack_onehot", 32'(bus.ack0 && bus.ack1), 32'd0);
                if (rsp_q.size() == 0) begin
                    check("unexpected_ack", 32'({bus.ack1, bus.ack0}), 32'd0);
                end else begin
                    r = rsp_q.pop_front();
                    check("ack_port", 32'(bus.ack1), 32'(r.port));
                    if (r.port) begin
                        check("err1", 32'(bus.err1), 32'(r.err));
                        check("err0_quiet", 32'(bus.err0), 32'd0);
                        check("dout1", bus.dout1, r.dout);
                        last1 = r.dout;
                    end else begin
                        check("err0", 32'(bus.err0), 32'(r.err));
                        check("err1_quiet", 32'(bus.err1), 32'd0);
                        check("dout0", bus.dout0, r.dout);
                        last0 = r.dout;
                    end
                    ack_port.push_back(r.port ? 1 : 0);
                    ack_cyc.push_back(cyc);
                end
            end else begin
                check("err_without_ack", 32'({bus.err1, bus.err0}), 32'd0);
            end
            if (bus.mem_we || bus.mem_re) begin
                if (acc_q.size() == 0) begin
                    check("unexpected_access", 32'({bus.mem_re, bus.mem_we}), 32'd0);
                end else begin
                    a = acc_q.pop_front();
                    check("mem_addr", bus.mem_addr, a.addr);
                    check("mem_we", 32'(bus.mem_we), 32'(a.we));
                    check("mem_re", 32'(bus.mem_re), 32'(!a.we));
                    check("mem_din", bus.mem_din, a.din);
                end
            end else if (phase != 2) begin
                check("bus_idle_addr", bus.mem_addr, 32'd0);
                check("bus_idle_din", bus.mem_din, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        bus.req0  = 1'b0;
        bus.req1  = 1'b0;
        bus.we0   = 1'b0;
        bus.we1   = 1'b0;
        bus.addr0 = '0;
        bus.addr1 = '0;
        bus.din0  = '0;
        bus.din1  = '0;
    endtask

    // One-cycle request, then wait out the transaction.
    task automatic issue(input logic p, input logic we, input logic [31:0] addr,
                         input logic [31:0] din);
        if (p) begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.din1 = din;
        end else begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.din0 = din;
        end
        tick();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        for (int i = 0; i < 256; i++) issue(1'(i % 2), 1'b1, 32'(i), $urandom());

        issue(1'b0, 1'b1, 32'd5, 32'hDEADBEEF);
        issue(1'b0, 1'b0, 32'd5, 32'h0);
        check("read_back_5", bus.dout0, 32'hDEADBEEF);

        issue(1'b1, 1'b0, 32'd256, 32'h0);
        check("illegal_dout1", bus.dout1, 32'd0);
        issue(1'b1, 1'b0, 32'd255, 32'h0);
        check("legal_255", bus.dout1, ref_mem[255]);

        // Reset lands on the ACCESS cycle of a write.
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'd7; bus.din0 = 32'h1234_5678;
        tick();
        bus.req0 = 1'b0;
        rst = 1'b1;
        #3;
        check("rst_blocks_we", 32'(bus.mem_we), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        issue(1'b0, 1'b0, 32'd7, 32'h0);
        check("rst_keeps_7", bus.dout0, ref_mem[7]);

        // Both requesters held high out of reset.
        rst = 1'b1;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'd10;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'd20;
        repeat (2) tick();
        ack_port.delete();
        ack_cyc.delete();
        rst = 1'b0;
        repeat (12) tick();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (3) tick();
        check("contention_acks", 32'(ack_port.size()), 32'd4);
        for (int i = 0; i < ack_port.size() && i < 4; i++)
            check("grant_order", 32'(ack_port[i]), 32'(i % 2));
        for (int i = 1; i < ack_cyc.size() && i < 4; i++)
            check("ack_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);

        for (int n = 0; n < 4000; n++) begin
            bus.req0  = ($urandom_range(0, 3) != 0);
            bus.req1  = ($urandom_range(0, 2) != 0);
            bus.we0   = 1'($urandom_range(0, 1));
            bus.we1   = 1'($urandom_range(0, 1));
            bus.addr0 = $urandom_range(0, 279);
            bus.addr1 = $urandom_range(0, 279);
            bus.din0  = $urandom();
            bus.din1  = $urandom();
            rst       = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        clear_inputs();
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 size, 256, number of 32-bit memory words; any address >= size is illegal.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0, req1  input  1 each  access request from requester 0/1.
REQ-005 we0, we1  input  1 each  1 = write, 0 = read.
REQ-006 addr0, addr1  input  32 each  word address.
REQ-007 din0, din1  input  32 each  write data.
REQ-008 ack0, ack1  output  1 each  one-cycle completion pulse to requester 0/1.
REQ-009 err0, err1  output  1 each  asserted with ack when the address was illegal.
REQ-010 dout0, dout1  output  32 each  read data for requester 0/1, valid with ack and held until that port's next ack.
REQ-011 mem_addr  output  32  address to the memory.
REQ-012 mem_din  output  32  write data to the memory.
REQ-013 mem_we  output  1  memory write enable; the memory writes on the clk edge.
REQ-014 mem_re  output  1  memory read enable.
REQ-015 mem_out  input  32  memory read data, combinational from mem_addr while mem_re=1.
REQ-016 busy  output  1  high whenever state != IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, ACCESS and RESP, and SHALL follow IDLE->ACCESS (any req high), ACCESS->RESP (always) and RESP->IDLE (always).
REQ-018 Requests SHALL be sampled only in IDLE; in the IDLE cycle the grantee's we, addr and din SHALL be latched, and these latched values SHALL drive the whole transaction.
REQ-019 Arbitration SHALL be round-robin: a single request wins outright; with both requests high the port named by the priority pointer wins, and after every grant the pointer SHALL move to the other port.
REQ-020 In ACCESS with a legal address, the arbiter SHALL drive mem_addr = latched addr, mem_we = latched we, mem_re = ~latched we and mem_din = latched din (0 for a read).
REQ-021 In ACCESS with an illegal address, mem_we and mem_re SHALL be 0 and the error flag SHALL be latched.
REQ-022 For a read, mem_out SHALL be captured into the grantee's dout register at the ACCESS->RESP edge.
REQ-023 For a write or an illegal access, the grantee's dout register SHALL be loaded with 0.
REQ-024 In RESP the arbiter SHALL pulse the grantee's ack for exactly one cycle, and err SHALL equal the latched error flag; the other port's ack, err and dout SHALL remain unchanged.
REQ-025 Latency SHALL be fixed: req sampled in IDLE cycle T -> memory access in T+1 -> ack in T+2; the peak rate SHALL be one access per 3 cycles.
REQ-026 Outside ACCESS, mem_addr, mem_din, mem_we and mem_re SHALL all be 0.
REQ-027 A requester that holds req high through its ack SHALL be treated as making a new request at the next IDLE, subject to round-robin.
REQ-028 Dropping req after the IDLE grant cycle SHALL NOT abort the transaction; it completes and acks.
REQ-029 A requester that keeps req low SHALL never receive ack.
REQ-030 A losing request held high SHALL be granted at the next IDLE, with a worst-case wait of one transaction (no starvation).

Reset
REQ-031 While rst=1, mem_we and mem_re SHALL be forced to 0 combinationally, so that no memory write occurs on a reset edge even in ACCESS.
REQ-032 On a rst edge, the state SHALL go to IDLE, the pointer to port 0, all acks, errs and busy to 0, and dout0/dout1 to 0.
REQ-033 Any in-flight transaction SHALL be discarded without an ack.
REQ-034 The first IDLE cycle after rst deasserts SHALL sample requests normally.

Verification
REQ-035 Single write then read: req0, we0=1, addr0=5, din0=0xDEADBEEF -> mem_we=1 and mem_addr=5 in T+1, ack0 in T+2 with dout0=0. A following read of addr 5 -> mem_re=1 in its ACCESS cycle, ack0 with dout0=0xDEADBEEF.
REQ-036 Contention: req0 and req1 held high from reset -> grants alternate 0,1,0,1; acks occur every 3 cycles; neither port waits more than one transaction.
REQ-037 Illegal address: req1 read addr1=256 -> mem_we=mem_re=0 throughout; ack1=1 with err1=1 and dout1=0; a legal addr 255 then succeeds with err1=0.
REQ-038 Reset mid-operation: rst=1 during the ACCESS of a write to addr 7 -> mem_we=0 that cycle, no ack, and a later read of addr 7 returns its prior value.
REQ-039 Short request: req0 high for only the IDLE cycle -> the transaction still completes and ack0 pulses once in T+2; busy is high in T+1 and T+2 only.
